rv32i_mem_access: RTL and testbench
===================================

// Module: rv32i_mem_access
// PURPOSE
//   Load/store unit between the execute stage and the data port of rv32i_syncDualPortRam.
//   - Converts byte-addressed RV32I load/store requests into word address, byte enables and lane-replicated write data.
//   - Extracts and sign/zero-extends load data returned by the synchronous RAM one cycle later.
//   - Buffers one load response under writeback backpressure.
//   - Flags misaligned and illegal accesses.
// PARAMETERS
//   ADDR_W  15  width of RAM word address (d_addr); byte address bits [ADDR_W+1:2] used, upper bits ignored (wrap)
// PORTS
//   clk         in   1       system clock, all state on rising edge
//   reset       in   1       synchronous, active-high
//   req_valid   in   1       request present
//   req_ready   out  1       request accepted when req_valid & req_ready
//   req_we      in   1       1 = store, 0 = load
//   req_funct3  in   3       000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
//   req_addr    in   32      byte address
//   req_wdata   in   32      store data (low bits significant)
//   req_rd      in   5       load destination register
//   d_addr      out  ADDR_W  RAM word address = req_addr[ADDR_W+1:2]
//   d_we        out  1       RAM write enable
//   d_be        out  4       RAM byte enables
//   d_wdata     out  32      RAM write data
//   d_rdata     in   32      RAM read data, valid cycle after address presented
//   rsp_valid   out  1       load result valid
//   rsp_ready   in   1       writeback accepts result
//   rsp_rd      out  5       destination register of result
//   rsp_data    out  32      extended load result
//   err_valid   out  1       one-cycle error pulse
//   err_cause   out  2       0 misaligned load, 1 misaligned store, 2 illegal funct3
//   err_addr    out  32      faulting byte address
// BEHAVIOUR
//   - Request path (combinational from req_*). acc = req_valid & req_ready & legal & aligned.
//     - d_we = acc & req_we.
//     - d_be: SB 4'b0001<<a[1:0]; SH 4'b0011<<a[1:0]; SW 4'b1111; loads and idle 4'b0000.
//     - d_wdata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
//     - d_addr always driven from req_addr.
//   - Alignment / legality:
//     - Misaligned: H/HU with a[0]=1, or W with a[1:0]!=0.
//     - Illegal: funct3 011/110/111, or store with 100/101.
//     - Illegal takes precedence over misaligned.
//     - A faulting request is consumed (handshake completes) with no RAM access.
//     - Next cycle: err_valid=1, err_cause and err_addr registered.
//   - Load pipeline state:
//     - load_pend is set on a legal load acceptance; it holds rd, a[1:0] and funct3.
//     - Cycle after acceptance: rsp_valid=1; rsp_data = extract(d_rdata), rsp_rd = pending rd.
//     - Extract: B/BU pick byte a[1:0]; H/HU pick half a[1]; sign- or zero-extend per funct3; W passes through.
//   - Backpressure: states EMPTY / PEND / HOLD.
//     - EMPTY -> PEND on load accept.
//     - PEND with rsp_ready=1: -> PEND if another load is accepted, else EMPTY.
//     - PEND with rsp_ready=0: capture extracted data into hold register -> HOLD.
//     - HOLD: rsp_valid=1 with held data, stable until rsp_ready=1 -> EMPTY.
//   - req_ready = !reset & state!=HOLD & !(state==PEND & !rsp_ready). Stores follow the same rule.
//   - Latency: store 0 cycles (RAM writes at the acceptance edge); load 1 cycle to rsp_valid.
//   - Throughput: 1 request per cycle.
//   - Reset (also mid-operation): state=EMPTY, pending or held load discarded (no rsp_valid after reset).
//     - rsp_valid=0, rsp_rd=0, rsp_data=0, err_valid=0, err_cause=0, err_addr=0.
//     - req_ready=0, d_we=0, d_be=0 while reset is high.
// TESTING
//   1. SW a=0x8, wdata=0xDEADBEEF -> same cycle d_addr=2, d_we=1, d_be=1111, d_wdata=0xDEADBEEF.
//   2. SB a=0x5, wdata=0x000000A5 -> d_addr=1, d_be=0010, d_wdata=0xA5A5A5A5.
//      SH a=0x6, wdata=0x1234 -> d_be=1100, d_wdata=0x12341234.
//   3. LB a=0x5 with d_rdata=0x123480FF next cycle -> rsp_valid=1, rsp_data=0xFFFFFF80.
//      LBU -> 0x00000080; LH a=0x6 with d_rdata=0x8001xxxx -> 0xFFFF8001; rsp_rd matches req_rd.
//   4. LW rd=7 accepted, rsp_ready=0 for 2 cycles, RAM data changes -> rsp_data held stable.
//      req_ready=0 during hold; after rsp_ready=1, one rsp with original data, req_ready returns to 1.
//   5. LW a=0x6 -> d_be=0000, d_we=0, next cycle err_valid=1, cause=0, addr=0x6, no rsp_valid.
//      SH a=0x3 -> cause=1; funct3=011 -> cause=2.
//   6. Load accepted, reset high the next cycle -> rsp_valid stays 0 through and after reset.
//      Back-to-back loads at 1/cycle with rsp_ready=1 -> one rsp per cycle, in order.

Source files
------------

// File: rtl/rv32i_mem_access_if.sv
// rv32i_mem_access_if: request, RAM data port, load response and error signals of the load/store unit
interface rv32i_mem_access_if #(parameter int ADDR_W = 15);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [4:0]        rsp_rd;
    logic [31:0]       rsp_data;
    logic              err_valid;
    logic [1:0]        err_cause;
    logic [31:0]       err_addr;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, d_rdata, rsp_ready,
        output req_ready, d_addr, d_we, d_be, d_wdata, rsp_valid, rsp_rd, rsp_data,
               err_valid, err_cause, err_addr
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, d_rdata, rsp_ready,
        input  req_ready, d_addr, d_we, d_be, d_wdata, rsp_valid, rsp_rd, rsp_data,
               err_valid, err_cause, err_addr
    );
endinterface

// File: rtl/rv32i_mem_access.sv
// rv32i_mem_access: RV32I load/store unit driving a synchronous RAM data port
module rv32i_mem_access #(
    parameter int ADDR_W = 15
) (
    input logic               clk,
    input logic               reset,
    rv32i_mem_access_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, PEND, HOLD} state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_rd;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic [31:0] r_hold;
    logic        r_err_valid;
    logic [1:0]  r_err_cause;
    logic [31:0] r_err_addr;

    logic [2:0]  w_f3;
    logic [1:0]  w_a;
    logic        w_illegal, w_misal, w_hs, w_acc, w_ld_acc, w_st_acc, w_rsp_valid;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_f3      = bus.req_funct3;
    assign w_a       = bus.req_addr[1:0];
    // 011/11x never legal; unsigned variants make no sense for stores
    assign w_illegal = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11) || (bus.req_we && w_f3[2]);
    assign w_misal   = !w_illegal && (((w_f3[1:0] == 2'b01) && w_a[0]) || ((w_f3[1:0] == 2'b10) && (w_a != 2'b00)));
    assign w_hs      = bus.req_valid && bus.req_ready;
    assign w_acc     = w_hs && !w_illegal && !w_misal;
    assign w_ld_acc  = w_acc && !bus.req_we;
    assign w_st_acc  = w_acc && bus.req_we;

    assign bus.req_ready = !reset && (r_state != HOLD) && !((r_state == PEND) && !bus.rsp_ready);
    assign bus.d_addr    = bus.req_addr[ADDR_W+1:2];
    assign bus.d_we      = w_st_acc;
    assign bus.d_be      = !w_st_acc ? 4'b0000 :
                           (w_f3[1:0] == 2'b00) ? 4'b0001 << w_a :
                           (w_f3[1:0] == 2'b01) ? 4'b0011 << w_a : 4'b1111;
    assign bus.d_wdata   = (w_f3[1:0] == 2'b00) ? {4{bus.req_wdata[7:0]}} :
                           (w_f3[1:0] == 2'b01) ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;

    assign w_byte = r_off[1] ? (r_off[0] ? bus.d_rdata[31:24] : bus.d_rdata[23:16])
                             : (r_off[0] ? bus.d_rdata[15:8]  : bus.d_rdata[7:0]);
    assign w_half = r_off[1] ? bus.d_rdata[31:16] : bus.d_rdata[15:0];
    assign w_ext  = (r_f3 == 3'b000) ? {{24{w_byte[7]}}, w_byte} :
                    (r_f3 == 3'b100) ? {24'd0, w_byte} :
                    (r_f3 == 3'b001) ? {{16{w_half[15]}}, w_half} :
                    (r_f3 == 3'b101) ? {16'd0, w_half} : bus.d_rdata;

    // reset blanks the response immediately so a pending load never surfaces
    assign w_rsp_valid   = !reset && (r_state != EMPTY);
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rd    = w_rsp_valid ? r_rd : 5'd0;
    assign bus.rsp_data  = !w_rsp_valid ? 32'd0 : (r_state == HOLD) ? r_hold : w_ext;
    assign bus.err_valid = r_err_valid;
    assign bus.err_cause = r_err_cause;
    assign bus.err_addr  = r_err_addr;

    // response slot: empty, live RAM data this cycle, or parked under backpressure
    always_comb begin
        w_next = (r_state == EMPTY) ? (w_ld_acc ? PEND : EMPTY) :
                 (r_state == PEND)  ? (bus.rsp_ready ? (w_ld_acc ? PEND : EMPTY) : HOLD) :
                 (bus.rsp_ready ? EMPTY : HOLD);
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= EMPTY;
        else       r_state <= w_next;
    end

    // pending-load context and hold buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd   <= '0;
            r_off  <= '0;
            r_f3   <= '0;
            r_hold <= '0;
        end else begin
            if (w_ld_acc) begin
                r_rd  <= bus.req_rd;
                r_off <= w_a;
                r_f3  <= w_f3;
            end
            if ((r_state == PEND) && !bus.rsp_ready) r_hold <= w_ext;
        end
    end

    // error pulse for a consumed faulting request; illegal outranks misaligned
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_valid <= 1'b0;
            r_err_cause <= '0;
            r_err_addr  <= '0;
        end else begin
            r_err_valid <= w_hs && (w_illegal || w_misal);
            if (w_hs && (w_illegal || w_misal)) begin
                r_err_cause <= w_illegal ? 2'd2 : {1'b0, bus.req_we};
                r_err_addr  <= bus.req_addr;
            end
        end
    end
endmodule

// File: tb/tb_rv32i_mem_access.sv
// tb_rv32i_mem_access: directed stimulus with queued expected responses checked by a monitor
module tb_rv32i_mem_access;
    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_tot  = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } rsp_t;
    typedef struct {
        logic [1:0]  cause;
        logic [31:0] addr;
    } err_t;
    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_t;

    rsp_t rq[$];
    err_t eq[$];

    rv32i_mem_access_if #(.ADDR_W(15)) bus();
    rv32i_mem_access #(.ADDR_W(15)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic put(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // monitor: compare every presented response/error against the scoreboard
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (rq.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_rsp: got rd %0d data %h expected no response", bus.rsp_rd, bus.rsp_data);
            end else begin
                chk("rsp_rd", {27'd0, bus.rsp_rd}, {27'd0, rq[0].rd});
                chk("rsp_data", bus.rsp_data, rq[0].data);
                if (bus.rsp_ready) void'(rq.pop_front());
            end
        end
        if (bus.err_valid === 1'b1) begin
            if (eq.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_err: got cause %0d addr %h expected no error", bus.err_cause, bus.err_addr);
            end else begin
                chk("err_cause", {30'd0, bus.err_cause}, {30'd0, eq[0].cause});
                chk("err_addr", bus.err_addr, eq[0].addr);
                void'(eq.pop_front());
            end
        end
    end

    initial begin
        ld_t lv[8];
        lv[0] = '{3'b000, 32'h5,  5'd3,  32'h123480FF, 32'hFFFFFF80};
        lv[1] = '{3'b100, 32'h5,  5'd4,  32'h123480FF, 32'h00000080};
        lv[2] = '{3'b001, 32'h6,  5'd5,  32'h80011234, 32'hFFFF8001};
        lv[3] = '{3'b101, 32'h6,  5'd6,  32'h80011234, 32'h00008001};
        lv[4] = '{3'b010, 32'h10, 5'd8,  32'hCAFEF00D, 32'hCAFEF00D};
        lv[5] = '{3'b000, 32'h7,  5'd9,  32'h80000000, 32'hFFFFFF80};
        lv[6] = '{3'b100, 32'h4,  5'd10, 32'h000000FF, 32'h000000FF};
        lv[7] = '{3'b001, 32'h0,  5'd11, 32'h00007FFF, 32'h00007FFF};

        reset         = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.d_rdata   = 32'h0;
        put(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 5'd0);
        tick;
        tick;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_d_we", {31'd0, bus.d_we}, 32'd0);
        chk("rst_d_be", {28'd0, bus.d_be}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_err_valid", {31'd0, bus.err_valid}, 32'd0);
        chk("rst_err_addr", bus.err_addr, 32'd0);
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        tick;

        put(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 5'd0);
        chk("sw_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("sw_d_addr", {17'd0, bus.d_addr}, 32'd2);
        chk("sw_d_we", {31'd0, bus.d_we}, 32'd1);
        chk("sw_d_be", {28'd0, bus.d_be}, 32'hF);
        chk("sw_d_wdata", bus.d_wdata, 32'hDEADBEEF);
        tick;
        put(1'b1, 3'b000, 32'h5, 32'h000000A5, 5'd0);
        chk("sb_d_addr", {17'd0, bus.d_addr}, 32'd1);
        chk("sb_d_be", {28'd0, bus.d_be}, 32'h2);
        chk("sb_d_wdata", bus.d_wdata, 32'hA5A5A5A5);
        tick;
        put(1'b1, 3'b001, 32'h6, 32'h00001234, 5'd0);
        chk("sh_d_be", {28'd0, bus.d_be}, 32'hC);
        chk("sh_d_wdata", bus.d_wdata, 32'h12341234);
        tick;
        put(1'b1, 3'b010, 32'h0002_0004, 32'h1, 5'd0);
        chk("wrap_d_addr", {17'd0, bus.d_addr}, 32'd1);
        tick;

        for (int i = 0; i < 8; i++) begin
            if (i > 0) bus.d_rdata = lv[i-1].rdata;
            put(1'b0, lv[i].f3, lv[i].addr, 32'h0, lv[i].rd);
            rq.push_back('{lv[i].rd, lv[i].exp});
            chk("ld_req_ready", {31'd0, bus.req_ready}, 32'd1);
            chk("ld_d_we", {31'd0, bus.d_we}, 32'd0);
            chk("ld_d_be", {28'd0, bus.d_be}, 32'd0);
            tick;
        end
        bus.req_valid = 1'b0;
        bus.d_rdata   = lv[7].rdata;
        tick;

        put(1'b0, 3'b010, 32'hC, 32'h0, 5'd7);
        rq.push_back('{5'd7, 32'h11112222});
        tick;
        bus.d_rdata   = 32'h11112222;
        bus.rsp_ready = 1'b0;
        put(1'b1, 3'b010, 32'h20, 32'h55555555, 5'd0);
        chk("pend_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("pend_d_we", {31'd0, bus.d_we}, 32'd0);
        tick;
        bus.d_rdata = 32'h33334444;
        #1;
        chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("hold_d_we", {31'd0, bus.d_we}, 32'd0);
        chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        tick;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick;
        chk("release_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

        put(1'b0, 3'b010, 32'h6, 32'h0, 5'd1);
        eq.push_back('{2'd0, 32'h6});
        chk("mis_lw_d_be", {28'd0, bus.d_be}, 32'd0);
        chk("mis_lw_req_ready", {31'd0, bus.req_ready}, 32'd1);
        tick;
        put(1'b1, 3'b001, 32'h3, 32'h1234, 5'd0);
        eq.push_back('{2'd1, 32'h3});
        chk("mis_sh_d_we", {31'd0, bus.d_we}, 32'd0);
        tick;
        put(1'b0, 3'b011, 32'h10, 32'h0, 5'd2);
        eq.push_back('{2'd2, 32'h10});
        tick;
        put(1'b1, 3'b101, 32'h1, 32'h0, 5'd0);
        eq.push_back('{2'd2, 32'h1});
        chk("ill_sthu_d_we", {31'd0, bus.d_we}, 32'd0);
        tick;
        bus.req_valid = 1'b0;
        tick;
        tick;

        put(1'b0, 3'b000, 32'h0, 32'h0, 5'd12);
        tick;
        reset = 1'b1;
        put(1'b1, 3'b010, 32'h8, 32'hFFFFFFFF, 5'd0);
        chk("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("midrst_rsp_rd", {27'd0, bus.rsp_rd}, 32'd0);
        chk("midrst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("midrst_d_be", {28'd0, bus.d_be}, 32'd0);
        tick;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("postrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        tick;
        chk("postrst2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        tick;
        tick;

        chk("rsp_queue_drained", rq.size(), 32'd0);
        chk("err_queue_drained", eq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
